// File: rtl/apb_write_master.sv
// APB3 write-only requester: buffers write commands in a small FIFO and issues them as SETUP/ACCESS transfers.
// Optional ACCESS-phase timeout is enabled with `define APB_WM_TIMEOUT_EN (err is tied 0 otherwise).
module apb_write_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]       count_reg;
  logic              full, push, pop;

  logic [ADDR_W-1:0] paddr_reg;
  logic [DATA_W-1:0] pwdata_reg;
  logic              done_reg, done_next;

  assign full      = (count_reg == FULL_CNT);
  assign push      = req_valid && !full;
  assign req_ready = !full;

  // Storage has no reset so it can map onto RAM; the PADDR/PWDATA registers act as the read stage.
  always_ff @(posedge PCLK) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= req_addr;
      data_mem[wr_ptr_reg] <= req_data;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef APB_WM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] wait_reg, wait_next;
  logic          err_reg, err_next;
  logic          timed_out;

  // The TIMEOUT-th consecutive low-PREADY ACCESS cycle ends the transfer.
  assign timed_out = !PREADY && (wait_reg == LIMIT);
  assign err       = err_reg;
`else
  logic timed_out;

  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    done_next  = 1'b0;
`ifdef APB_WM_TIMEOUT_EN
    err_next   = 1'b0;
    wait_next  = wait_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
`ifdef APB_WM_TIMEOUT_EN
        wait_next  = '0;
`endif
      end
      ACCESS: begin
        if (PREADY || timed_out) begin
          done_next = PREADY;
`ifdef APB_WM_TIMEOUT_EN
          err_next  = !PREADY;
`endif
          if (count_reg != '0) begin
            pop        = 1'b1;
            state_next = SETUP;
          end else begin
            state_next = IDLE;
          end
        end else begin
`ifdef APB_WM_TIMEOUT_EN
          wait_next = wait_reg + 1'b1;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg  <= IDLE;
      paddr_reg  <= '0;
      pwdata_reg <= '0;
      done_reg   <= 1'b0;
`ifdef APB_WM_TIMEOUT_EN
      wait_reg   <= '0;
      err_reg    <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
`ifdef APB_WM_TIMEOUT_EN
      wait_reg  <= wait_next;
      err_reg   <= err_next;
`endif
      if (pop) begin
        paddr_reg  <= addr_mem[rd_ptr_reg];
        pwdata_reg <= data_mem[rd_ptr_reg];
      end
    end
  end

  assign PSEL    = (state_reg != IDLE);
  assign PENABLE = (state_reg == ACCESS);
  assign PWRITE  = PSEL;
  assign PADDR   = paddr_reg;
  assign PWDATA  = pwdata_reg;
  assign busy    = (count_reg != '0) || (state_reg != IDLE);
  assign done    = done_reg;

endmodule
